hpdcache_mshr_mtgt: RTL and testbench

//  Fully-associative multi-target MSHR: next generation of the HPDcache miss tracker.
//  A secondary miss to an in-flight line merges into that line's target list instead of stalling.
//  On refill ack the block replays the queued targets one per cycle to the refill/response path.

---
 rtl/hpdcache_mshr_mtgt.sv | 223 ++++++++++++++++++++++
 tb/tb_hpdcache_mshr_mtgt.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hpdcache_mshr_mtgt.sv
// Fully-associative multi-target MSHR: secondary misses merge into an in-flight line's target list.
// Latency: alloc lookup is combinational, state updates at the next edge; replay starts the cycle after ack.
// Backpressure: alloc stalls on a full table, a full target list or a draining line; a stalled replay holds its outputs.
//
// Ports:
//   clk_i, rst_ni             clock, async active-low reset
//   empty_o, full_o           table occupancy (registered state)
//   alloc_*                   miss request in; ready/primary/id out
//   ack_valid_i/ready_o/id_i  refill acknowledgement for one entry
//   rpl_*                     replayed targets, one per cycle, rpl_last_o on the final one
module hpdcache_mshr_mtgt #(
  parameter  int unsigned NEntries = 4,
  parameter  int unsigned NTargets = 4,
  parameter  int unsigned NlineW   = 26,
  parameter  int unsigned TidW     = 6,
  parameter  int unsigned SidW     = 3,
  parameter  int unsigned WordW    = 3,
  parameter  int unsigned WayW     = 2,
  localparam int unsigned IdW      = (NEntries > 1) ? $clog2(NEntries) : 1,
  localparam int unsigned CntW     = $clog2(NTargets + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic              empty_o,
  output logic              full_o,
  input  logic              alloc_valid_i,
  output logic              alloc_ready_o,
  input  logic [NlineW-1:0] alloc_nline_i,
  input  logic [TidW-1:0]   alloc_tid_i,
  input  logic [SidW-1:0]   alloc_sid_i,
  input  logic [WordW-1:0]  alloc_word_i,
  input  logic [WayW-1:0]   alloc_victim_way_i,
  input  logic              alloc_need_rsp_i,
  output logic              alloc_primary_o,
  output logic [IdW-1:0]    alloc_id_o,
  input  logic              ack_valid_i,
  output logic              ack_ready_o,
  input  logic [IdW-1:0]    ack_id_i,
  output logic              rpl_valid_o,
  input  logic              rpl_ready_i,
  output logic [NlineW-1:0] rpl_nline_o,
  output logic [TidW-1:0]   rpl_tid_o,
  output logic [SidW-1:0]   rpl_sid_o,
  output logic [WordW-1:0]  rpl_word_o,
  output logic [WayW-1:0]   rpl_way_o,
  output logic              rpl_need_rsp_o,
  output logic              rpl_last_o
);

  typedef struct packed {
    logic [TidW-1:0]  tid;
    logic [SidW-1:0]  sid;
    logic [WordW-1:0] word;
    logic             need_rsp;
  } tgt_t;

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_e;

  logic [NEntries-1:0] valid_q, valid_d;
  logic [NEntries-1:0] drain_q, drain_d;
  logic [NlineW-1:0]   nline_q [NEntries];
  logic [NlineW-1:0]   nline_d [NEntries];
  logic [WayW-1:0]     way_q   [NEntries];
  logic [WayW-1:0]     way_d   [NEntries];
  logic [CntW-1:0]     cnt_q   [NEntries];
  logic [CntW-1:0]     cnt_d   [NEntries];
  tgt_t                tgt_q   [NEntries][NTargets];
  tgt_t                tgt_d   [NEntries][NTargets];

  state_e          state_q, state_d;
  logic [IdW-1:0]  ack_id_q, ack_id_d;

  logic            hit, free_found;
  logic [IdW-1:0]  hit_idx, free_idx;
  logic            alloc_fire, ack_fire, pop, rpl_last;
  tgt_t            new_tgt, head_tgt;

  assign empty_o = ~|valid_q;
  assign full_o  = &valid_q;

  // Lookup uses registered valid only, so an entry freed at an edge is reusable one cycle later.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < NEntries; i++) begin
      if (valid_q[i] && nline_q[i] == alloc_nline_i) begin
        hit     = 1'b1;
        hit_idx = IdW'(i);
      end
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IdW'(i);
      end
    end
  end

  assign alloc_ready_o   = rst_ni & (hit ? (!drain_q[hit_idx] && cnt_q[hit_idx] != CntW'(NTargets))
                                         : free_found);
  assign alloc_primary_o = ~hit;
  assign alloc_id_o      = hit ? hit_idx : free_idx;
  assign alloc_fire      = alloc_valid_i & alloc_ready_o;
  assign new_tgt         = '{tid: alloc_tid_i, sid: alloc_sid_i, word: alloc_word_i,
                             need_rsp: alloc_need_rsp_i};

  assign ack_fire = ack_valid_i & ack_ready_o;
  assign rpl_last = (cnt_q[ack_id_q] == CntW'(1));
  assign pop      = rpl_valid_o & rpl_ready_i;

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      ack_id_q <= '0;
    end else begin
      state_q  <= state_d;
      ack_id_q <= ack_id_d;
    end
  end

  // FSM: next state. An ack to an invalid entry is consumed without effect.
  always_comb begin
    state_d  = state_q;
    ack_id_d = ack_id_q;
    case (state_q)
      IDLE: begin
        if (ack_fire && valid_q[ack_id_i]) begin
          state_d  = DRAIN;
          ack_id_d = ack_id_i;
        end
      end
      DRAIN: begin
        if (pop && rpl_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs. Replay fields are forced to zero outside DRAIN.
  always_comb begin
    ack_ready_o    = rst_ni & (state_q == IDLE);
    rpl_valid_o    = (state_q == DRAIN);
    head_tgt       = tgt_q[ack_id_q][0];
    rpl_nline_o    = '0;
    rpl_way_o      = '0;
    rpl_tid_o      = '0;
    rpl_sid_o      = '0;
    rpl_word_o     = '0;
    rpl_need_rsp_o = 1'b0;
    rpl_last_o     = 1'b0;
    if (state_q == DRAIN) begin
      rpl_nline_o    = nline_q[ack_id_q];
      rpl_way_o      = way_q[ack_id_q];
      rpl_tid_o      = head_tgt.tid;
      rpl_sid_o      = head_tgt.sid;
      rpl_word_o     = head_tgt.word;
      rpl_need_rsp_o = head_tgt.need_rsp;
      rpl_last_o     = rpl_last;
    end
  end

  // Entry next state. A merge never targets the draining entry (it is stalled),
  // so append and pop never touch the same target list in one cycle.
  always_comb begin
    valid_d = valid_q;
    drain_d = drain_q;
    nline_d = nline_q;
    way_d   = way_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    for (int i = 0; i < NEntries; i++) begin
      if (alloc_fire && alloc_id_o == IdW'(i)) begin
        if (!hit) begin
          valid_d[i]    = 1'b1;
          drain_d[i]    = 1'b0;
          nline_d[i]    = alloc_nline_i;
          way_d[i]      = alloc_victim_way_i;
          cnt_d[i]      = CntW'(1);
          tgt_d[i][0]   = new_tgt;
        end else begin
          for (int t = 0; t < NTargets; t++) begin
            if (CntW'(t) == cnt_q[i]) tgt_d[i][t] = new_tgt;
          end
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
      if (ack_fire && valid_q[i] && ack_id_i == IdW'(i)) drain_d[i] = 1'b1;
      if (pop && ack_id_q == IdW'(i)) begin
        for (int t = 0; t < NTargets - 1; t++) tgt_d[i][t] = tgt_q[i][t+1];
        cnt_d[i] = cnt_q[i] - CntW'(1);
        if (rpl_last) begin
          valid_d[i] = 1'b0;
          drain_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      drain_q <= '0;
      for (int i = 0; i < NEntries; i++) begin
        nline_q[i] <= '0;
        way_q[i]   <= '0;
        cnt_q[i]   <= '0;
        for (int t = 0; t < NTargets; t++) tgt_q[i][t] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      drain_q <= drain_d;
      nline_q <= nline_d;
      way_q   <= way_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
    end
  end

  ack_to_valid_entry: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (ack_valid_i && ack_ready_o) |-> valid_q[ack_id_i]);

endmodule

// File: tb/tb_hpdcache_mshr_mtgt.sv
module tb_hpdcache_mshr_mtgt;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        empty_o, full_o;
  logic        alloc_valid_i = 1'b0;
  logic        alloc_ready_o;
  logic [25:0] alloc_nline_i = '0;
  logic [5:0]  alloc_tid_i = '0;
  logic [2:0]  alloc_sid_i = '0;
  logic [2:0]  alloc_word_i = '0;
  logic [1:0]  alloc_victim_way_i = '0;
  logic        alloc_need_rsp_i = 1'b0;
  logic        alloc_primary_o;
  logic [1:0]  alloc_id_o;
  logic        ack_valid_i = 1'b0;
  logic        ack_ready_o;
  logic [1:0]  ack_id_i = '0;
  logic        rpl_valid_o;
  logic        rpl_ready_i = 1'b0;
  logic [25:0] rpl_nline_o;
  logic [5:0]  rpl_tid_o;
  logic [2:0]  rpl_sid_o;
  logic [2:0]  rpl_word_o;
  logic [1:0]  rpl_way_o;
  logic        rpl_need_rsp_o;
  logic        rpl_last_o;

  hpdcache_mshr_mtgt dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .empty_o(empty_o), .full_o(full_o),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
    .alloc_nline_i(alloc_nline_i), .alloc_tid_i(alloc_tid_i), .alloc_sid_i(alloc_sid_i),
    .alloc_word_i(alloc_word_i), .alloc_victim_way_i(alloc_victim_way_i),
    .alloc_need_rsp_i(alloc_need_rsp_i), .alloc_primary_o(alloc_primary_o),
    .alloc_id_o(alloc_id_o), .ack_valid_i(ack_valid_i), .ack_ready_o(ack_ready_o),
    .ack_id_i(ack_id_i), .rpl_valid_o(rpl_valid_o), .rpl_ready_i(rpl_ready_i),
    .rpl_nline_o(rpl_nline_o), .rpl_tid_o(rpl_tid_o), .rpl_sid_o(rpl_sid_o),
    .rpl_word_o(rpl_word_o), .rpl_way_o(rpl_way_o), .rpl_need_rsp_o(rpl_need_rsp_o),
    .rpl_last_o(rpl_last_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       rdy;
    logic       prim;
    logic [1:0] id;
  } exp_alloc_t;

  typedef struct {
    logic [25:0] nline;
    logic [1:0]  way;
    logic [5:0]  tid;
    logic        last;
  } exp_rpl_t;

  exp_alloc_t alloc_q[$];
  exp_rpl_t   rpl_q[$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: sample away from the active edge.
  always @(negedge clk_i) begin
    if (rst_ni && alloc_valid_i) begin
      if (alloc_q.size() == 0) begin
        chk("alloc_unexpected", 32'd1, 32'd0);
      end else begin
        exp_alloc_t e;
        e = alloc_q.pop_front();
        chk("alloc_ready", {31'd0, alloc_ready_o}, {31'd0, e.rdy});
        if (e.rdy) begin
          chk("alloc_primary", {31'd0, alloc_primary_o}, {31'd0, e.prim});
          chk("alloc_id", {30'd0, alloc_id_o}, {30'd0, e.id});
        end
      end
    end
    if (rpl_valid_o && rpl_ready_i) begin
      if (rpl_q.size() == 0) begin
        chk("rpl_unexpected", 32'd1, 32'd0);
      end else begin
        exp_rpl_t r;
        r = rpl_q.pop_front();
        chk("rpl_nline", {6'd0, rpl_nline_o}, {6'd0, r.nline});
        chk("rpl_way", {30'd0, rpl_way_o}, {30'd0, r.way});
        chk("rpl_tid", {26'd0, rpl_tid_o}, {26'd0, r.tid});
        chk("rpl_sid", {29'd0, rpl_sid_o}, {29'd0, r.tid[2:0]});
        chk("rpl_word", {29'd0, rpl_word_o}, {29'd0, r.tid[5:3]});
        chk("rpl_need_rsp", {31'd0, rpl_need_rsp_o}, {31'd0, r.tid[0]});
        chk("rpl_last", {31'd0, rpl_last_o}, {31'd0, r.last});
      end
    end
  end

  // One-cycle alloc attempt; sid/word/need_rsp are derived from tid so replays can be checked.
  task automatic do_alloc(input logic [25:0] nl, input logic [1:0] way, input logic [5:0] tid,
                          input logic erdy, input logic eprim, input logic [1:0] eid);
    exp_alloc_t e;
    e.rdy = erdy; e.prim = eprim; e.id = eid;
    alloc_q.push_back(e);
    alloc_valid_i      = 1'b1;
    alloc_nline_i      = nl;
    alloc_victim_way_i = way;
    alloc_tid_i        = tid;
    alloc_sid_i        = tid[2:0];
    alloc_word_i       = tid[5:3];
    alloc_need_rsp_i   = tid[0];
    @(posedge clk_i); #1;
    alloc_valid_i = 1'b0;
  endtask

  task automatic exp_rpl(input logic [25:0] nl, input logic [1:0] way, input logic [5:0] tid,
                         input logic last);
    exp_rpl_t r;
    r.nline = nl; r.way = way; r.tid = tid; r.last = last;
    rpl_q.push_back(r);
  endtask

  task automatic do_ack(input logic [1:0] id);
    chk("ack_ready_idle", {31'd0, ack_ready_o}, 32'd1);
    ack_valid_i = 1'b1;
    ack_id_i    = id;
    @(posedge clk_i); #1;
    ack_valid_i = 1'b0;
  endtask

  localparam logic [25:0] LA = 26'h100, LB = 26'h200, LC = 26'h300, LD = 26'h400, LE = 26'h500;

  initial begin
    logic [5:0] btids [3];
    btids[0] = 6'd10; btids[1] = 6'd11; btids[2] = 6'd12;

    // 1: reset state and first primary allocation
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_empty", {31'd0, empty_o}, 32'd1);
    chk("rst_full", {31'd0, full_o}, 32'd0);
    chk("rst_alloc_ready", {31'd0, alloc_ready_o}, 32'd0);
    chk("rst_ack_ready", {31'd0, ack_ready_o}, 32'd0);
    chk("rst_rpl_valid", {31'd0, rpl_valid_o}, 32'd0);
    chk("rst_rpl_last", {31'd0, rpl_last_o}, 32'd0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    chk("idle_ack_ready", {31'd0, ack_ready_o}, 32'd1);
    chk("pre_alloc_empty", {31'd0, empty_o}, 32'd1);
    do_alloc(LA, 2'd1, 6'd1, 1'b1, 1'b1, 2'd0);
    chk("post_alloc_empty", {31'd0, empty_o}, 32'd0);

    // 2: three merges fill the target list, the fifth stalls
    do_alloc(LA, 2'd3, 6'd2, 1'b1, 1'b0, 2'd0);
    do_alloc(LA, 2'd3, 6'd3, 1'b1, 1'b0, 2'd0);
    do_alloc(LA, 2'd3, 6'd4, 1'b1, 1'b0, 2'd0);
    do_alloc(LA, 2'd3, 6'd5, 1'b0, 1'b0, 2'd0);

    // 3: drain line A on four consecutive cycles
    exp_rpl(LA, 2'd1, 6'd1, 1'b0);
    exp_rpl(LA, 2'd1, 6'd2, 1'b0);
    exp_rpl(LA, 2'd1, 6'd3, 1'b0);
    exp_rpl(LA, 2'd1, 6'd4, 1'b1);
    rpl_ready_i = 1'b1;
    do_ack(2'd0);
    repeat (4) @(posedge clk_i);
    #1;
    chk("drain4_left", rpl_q.size(), 32'd0);
    chk("drain4_empty", {31'd0, empty_o}, 32'd1);
    chk("drain4_rpl_valid", {31'd0, rpl_valid_o}, 32'd0);
    rpl_ready_i = 1'b0;

    // 4: fill all entries, new line stalls, hit to B still merges
    do_alloc(LA, 2'd1, 6'd30, 1'b1, 1'b1, 2'd0);
    do_alloc(LB, 2'd2, 6'd10, 1'b1, 1'b1, 2'd1);
    do_alloc(LC, 2'd3, 6'd20, 1'b1, 1'b1, 2'd2);
    chk("three_full", {31'd0, full_o}, 32'd0);
    do_alloc(LD, 2'd0, 6'd40, 1'b1, 1'b1, 2'd3);
    chk("four_full", {31'd0, full_o}, 32'd1);
    do_alloc(LE, 2'd1, 6'd50, 1'b0, 1'b0, 2'd0);
    do_alloc(LB, 2'd0, 6'd11, 1'b1, 1'b0, 2'd1);
    do_alloc(LB, 2'd0, 6'd12, 1'b1, 1'b0, 2'd1);

    // 5: stalled drain of B, pending ack to C waits for IDLE
    exp_rpl(LB, 2'd2, 6'd10, 1'b0);
    exp_rpl(LB, 2'd2, 6'd11, 1'b0);
    exp_rpl(LB, 2'd2, 6'd12, 1'b1);
    exp_rpl(LC, 2'd3, 6'd20, 1'b1);
    do_ack(2'd1);
    chk("b_rpl_valid", {31'd0, rpl_valid_o}, 32'd1);
    chk("b_ack_ready", {31'd0, ack_ready_o}, 32'd0);
    chk("b_first_tid", {26'd0, rpl_tid_o}, 32'd10);
    chk("b_first_nline", {6'd0, rpl_nline_o}, {6'd0, LB});
    do_alloc(LB, 2'd0, 6'd13, 1'b0, 1'b0, 2'd0);
    ack_valid_i = 1'b1;
    ack_id_i    = 2'd2;
    for (int k = 0; k < 3; k++) begin
      chk("hold_tid", {26'd0, rpl_tid_o}, {26'd0, btids[k]});
      chk("hold_last", {31'd0, rpl_last_o}, (k == 2) ? 32'd1 : 32'd0);
      chk("drain_ack_ready", {31'd0, ack_ready_o}, 32'd0);
      rpl_ready_i = 1'b1;
      @(posedge clk_i); #1;
      rpl_ready_i = 1'b0;
      if (k < 2) begin
        @(posedge clk_i); #1;
      end
    end
    chk("b_done_ack_ready", {31'd0, ack_ready_o}, 32'd1);
    @(posedge clk_i); #1;
    ack_valid_i = 1'b0;
    chk("c_rpl_valid", {31'd0, rpl_valid_o}, 32'd1);
    chk("c_tid", {26'd0, rpl_tid_o}, 32'd20);
    rpl_ready_i = 1'b1;
    @(posedge clk_i); #1;
    rpl_ready_i = 1'b0;
    chk("c_done_rpl_valid", {31'd0, rpl_valid_o}, 32'd0);
    chk("bc_left", rpl_q.size(), 32'd0);
    chk("bc_not_full", {31'd0, full_o}, 32'd0);

    // 6: reset in the middle of a four-target drain
    do_alloc(LA, 2'd0, 6'd31, 1'b1, 1'b0, 2'd0);
    do_alloc(LA, 2'd0, 6'd32, 1'b1, 1'b0, 2'd0);
    do_alloc(LA, 2'd0, 6'd33, 1'b1, 1'b0, 2'd0);
    exp_rpl(LA, 2'd1, 6'd30, 1'b0);
    exp_rpl(LA, 2'd1, 6'd31, 1'b0);
    rpl_ready_i = 1'b1;
    do_ack(2'd0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni      = 1'b0;
    rpl_ready_i = 1'b0;
    #1;
    chk("mid_rst_rpl_valid", {31'd0, rpl_valid_o}, 32'd0);
    chk("mid_rst_empty", {31'd0, empty_o}, 32'd1);
    chk("mid_rst_ack_ready", {31'd0, ack_ready_o}, 32'd0);
    chk("mid_rst_left", rpl_q.size(), 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("post_rst_rpl_valid", {31'd0, rpl_valid_o}, 32'd0);
    chk("post_rst_empty", {31'd0, empty_o}, 32'd1);
    chk("alloc_left", alloc_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, expected finish before %0t", $time);
    $fatal(1);
  end

endmodule
